// File: rtl/program_loader.sv
// Streams 3-byte instructions into instruction RAM, holding the CPU in reset until the load is done.
// One word per 4 cycles at best; aborts to ERROR after TIMEOUT idle RECV cycles.
module program_loader #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  word_count,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        ram_we,
   output logic [7:0]  ram_addr,
   output logic [23:0] ram_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    addr_q, addr_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [15:0]   word_q, word_d;
   logic [7:0]    ram_addr_q, ram_addr_d;
   logic [23:0]   ram_wdata_q, ram_wdata_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      word_d      = word_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               cnt_d   = word_count;
               addr_d  = 8'd0;
               idx_d   = 2'd0;
               tmo_d   = '0;
               state_d = (word_count == 8'd0) ? S_DONE : S_RECV;
            end
         end
         S_RECV: begin
            if (in_valid) begin
               tmo_d = '0;
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0:    word_d[15:8] = in_data;
                  2'd1:    word_d[7:0]  = in_data;
                  default: begin
                     ram_wdata_d = {word_q, in_data};
                     ram_addr_d  = addr_q;
                     idx_d       = 2'd0;
                     state_d     = S_WRITE;
                  end
               endcase
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // partial word is dropped; the next start begins a fresh word
               idx_d   = 2'd0;
               tmo_d   = '0;
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WRITE: begin
            if (addr_q == cnt_q - 8'd1) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + 8'd1;
               tmo_d   = '0;
               state_d = S_RECV;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         addr_q      <= 8'd0;
         idx_q       <= 2'd0;
         tmo_q       <= '0;
         word_q      <= 16'd0;
         ram_addr_q  <= 8'd0;
         ram_wdata_q <= 24'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         word_q      <= word_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // status outputs decode the state flop directly, so reset clears them at once
   assign in_ready  = (state_q == S_RECV);
   assign ram_we    = (state_q == S_WRITE);
   assign busy      = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERROR);
   assign cpu_hold  = (state_q != S_DONE);
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter TIMEOUT, default 255: max idle cycles in RECV before abort.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a load; sampled in IDLE, DONE, ERROR only.
REQ-005 word_count  input  8  number of 24-bit instructions to load; latched on accepted start.
REQ-006 in_data  input  8  incoming program byte.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 ram_we  output  1  single-cycle instruction RAM write strobe.
REQ-010 ram_addr  output  8  RAM write address, same width as the program counter.
REQ-011 ram_wdata  output  24  assembled instruction word.
REQ-012 cpu_hold  output  1  holds CPU in reset while high.
REQ-013 busy  output  1  load in progress (RECV or WRITE).
REQ-014 done  output  1  load completed successfully; level.
REQ-015 error  output  1  load aborted on timeout; level.

Function
REQ-016 States: IDLE, RECV, WRITE, DONE, ERROR; exactly one active.
REQ-017 IDLE/DONE/ERROR + start=1: latch word_count, clear addr and byte index to 0, clear timeout counter; go RECV, or DONE directly if word_count=0 (no writes).
REQ-018 start in RECV or WRITE is ignored.
REQ-019 in_ready=1 only in RECV; byte accepted on edge where in_valid & in_ready.
REQ-020 Byte order MSB first: byte0 -> word[23:16] (opcode, rs), byte1 -> [15:8] (rt, rd), byte2 -> [7:0] (shamt).
REQ-021 Each accepted byte increments byte index; acceptance of byte2 moves to WRITE and resets index to 0.
REQ-022 WRITE lasts exactly one cycle: ram_we=1, ram_addr=current addr, ram_wdata=assembled word; in_ready=0.
REQ-023 From WRITE: if addr = latched word_count-1 go DONE, else addr+1 and go RECV.
REQ-024 ram_we=0 in all states except WRITE; ram_addr/ram_wdata hold last values otherwise.
REQ-025 Timeout counter clears on entry to RECV and on each accepted byte, increments each RECV cycle without acceptance; reaching TIMEOUT moves to ERROR, discarding any partial word.
REQ-026 Byte accepted on the same cycle the counter would reach TIMEOUT: acceptance wins, no error.
REQ-027 word_count=255 (max): addresses 0..254 written; address never wraps.
REQ-028 busy=1 in RECV/WRITE; done=1 only in DONE; error=1 only in ERROR.
REQ-029 cpu_hold=1 in every state except DONE; deasserts on the first cycle of DONE.
REQ-030 Throughput: one word per 4 cycles minimum (3 accept + 1 write) with in_valid held high.

Reset
REQ-031 rst=1 asynchronously forces IDLE; in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, error=0, cpu_hold=1, byte index, timeout counter, latched count all 0.
REQ-032 rst mid-load aborts immediately; no further ram_we; loaded words are not restored; next load requires a new start.

Verification
REQ-033 start, word_count=2, bytes 0x1A,0x23,0x40,0xF0,0x00,0x05 streamed with in_valid=1 -> ram_we pulses at addr 0 data 0x1A2340 and addr 1 data 0xF00005, done=1 and cpu_hold=0 on cycle 9 after start.
REQ-034 start with word_count=0 -> DONE next cycle, no ram_we, cpu_hold=0.
REQ-035 TIMEOUT=4, start, 2 bytes then in_valid=0 -> ERROR after 4 idle cycles, error=1, cpu_hold=1, no ram_we; new start reloads from addr 0.
REQ-036 in_valid toggling 1/0 every cycle, word_count=3 -> three correct writes at addr 0,1,2, no dropped or duplicated bytes.
REQ-037 rst asserted during WRITE of word 1 -> outputs return to reset values asynchronously, ram_we drops same cycle, state IDLE.
REQ-038 start pulsed during RECV -> ignored; addr and byte index unaffected; load completes normally.
